// File: rtl/bp_pkg.sv
// Shared types, counter encoding constants and saturating-counter helper for the
// branch pattern history table.
package bp_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int unsigned CTR_W_MAX = 8;
  localparam int unsigned CTR_W_DEF = 2;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  localparam ctr_t CTR_MIN = '0;
  localparam ctr_t CTR_MAX = ctr_t'((1 << CTR_W_DEF) - 1);
  localparam ctr_t WEAK_T  = ctr_t'(1 << (CTR_W_DEF - 1));

  function automatic ctr_t ctr_max(input int unsigned w);
    return ctr_t'((1 << w) - 1);
  endfunction

  // Smallest counter value that predicts taken for a w-bit counter.
  function automatic ctr_t weak_t(input int unsigned w);
    return ctr_t'(1 << (w - 1));
  endfunction

  function automatic ctr_t sat_next(input ctr_t ctr, input logic taken, input int unsigned w);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr < ctr_max(w)) res = ctr + ctr_t'(1);
    end else begin
      if (ctr > CTR_MIN) res = ctr - ctr_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational saturating next value for one CTR_W-bit direction counter.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_next_c
);

  assign o_next_c = CTR_W'(sat_next(ctr_t'(i_ctr), i_taken, CTR_W));

endmodule

// File: rtl/bp_pattern_table.sv
// Gshare-indexed pattern history table of saturating counters with an
// initialisation sweep after reset and write-first bypass on lookup/update collision.
module bp_pattern_table
  import bp_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned GHR_W  = 6,
  parameter int unsigned PC_LSB = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready_o,
  input  logic             pred_valid_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sweep, w_sweep_nxt;
  logic [CTR_W-1:0] r_tbl [ENTRIES];

  logic             r_ready, r_pred_valid, r_pred_taken;
  logic [IDX_W-1:0] r_pred_idx;

  logic             w_run, w_accept, w_upd_en, w_bypass, w_rd_taken;
  logic [IDX_W-1:0] w_ghr_ext, w_idx;
  logic [CTR_W-1:0] w_upd_cur, w_upd_next, w_rd_ctr;
  logic             w_unused_pc;

  assign w_unused_pc = ^pred_pc_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  // Sweep one entry per cycle, then hand the table over to lookups/updates.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_run       = 1'b0;
    case (r_state)
      INIT: begin
        w_sweep_nxt = r_sweep + IDX_W'(1);
        if (r_sweep == IDX_W'(ENTRIES - 1)) w_state_nxt = RUN;
      end
      RUN:     w_run = 1'b1;
      default: w_state_nxt = INIT;
    endcase
  end

  assign w_accept = pred_valid_i & w_run;
  assign w_upd_en = upd_valid_i & w_run;
  assign w_idx    = pred_pc_i[PC_LSB +: IDX_W] ^ w_ghr_ext;

  assign w_upd_cur = r_tbl[upd_idx_i];

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat (
    .i_ctr    (w_upd_cur),
    .i_taken  (upd_taken_i),
    .o_next_c (w_upd_next)
  );

  // Write-first: a colliding lookup sees the counter value being written this cycle.
  assign w_bypass   = w_upd_en && (upd_idx_i == w_idx);
  assign w_rd_ctr   = w_bypass ? w_upd_next : r_tbl[w_idx];
  assign w_rd_taken = ctr_t'(w_rd_ctr) >= weak_t(CTR_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT)  r_tbl[r_sweep]   <= CTR_W'(CTR_MIN);
      else if (w_upd_en)    r_tbl[upd_idx_i] <= w_upd_next;
    end
  end

  // History shifts only on resolved branches, so it is never speculative.
  generate
    if (GHR_W == 0) begin : g_bimodal
      assign w_ghr_ext = '0;
    end else begin : g_ghr
      logic [GHR_W-1:0] r_ghr;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ghr <= '0;
        end else if (w_upd_en) begin
          if (GHR_W == 1) r_ghr <= GHR_W'(upd_taken_i);
          else            r_ghr <= GHR_W'({r_ghr, upd_taken_i});
        end
      end
      assign w_ghr_ext = IDX_W'(r_ghr);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else begin
      r_ready      <= (w_state_nxt == RUN);
      r_pred_valid <= w_accept;
      if (w_accept) begin
        r_pred_taken <= w_rd_taken;
        r_pred_idx   <= w_idx;
      end
    end
  end

  assign ready_o      = r_ready;
  assign pred_valid_o = r_pred_valid;
  assign pred_taken_o = r_pred_taken;
  assign pred_idx_o   = r_pred_idx;

endmodule

// File: tb/tb_bp_pattern_table.sv
// Randomised scoreboard bench for bp_pattern_table against an array-of-integers
// reference model of the prediction table and branch history.
module tb_bp_pattern_table;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned GHR_W   = 6;
  localparam int unsigned PC_LSB  = 2;
  localparam int          ENTRIES = 64;
  localparam int          CMAX    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ready_o;
  logic             pred_valid_i = 1'b0;
  logic [XLEN-1:0]  pred_pc_i = '0;
  logic             pred_valid_o;
  logic             pred_taken_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             upd_valid_i = 1'b0;
  logic [IDX_W-1:0] upd_idx_i = '0;
  logic             upd_taken_i = 1'b0;

  always #5 clk = ~clk;

  bp_pattern_table #(
    .XLEN(XLEN), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W), .PC_LSB(PC_LSB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready_o      (ready_o),
    .pred_valid_i (pred_valid_i),
    .pred_pc_i    (pred_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .pred_idx_o   (pred_idx_o),
    .upd_valid_i  (upd_valid_i),
    .upd_idx_i    (upd_idx_i),
    .upd_taken_i  (upd_taken_i)
  );

  typedef struct {
    int idx;
    bit tk;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   m_ctr[ENTRIES];
  int   m_ghr;
  int   m_cnt;
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   mon_en;
  int   lst_idx;
  bit   lst_tk;

  // Cycle count and cycles elapsed since reset (saturating at ENTRIES = table ready).
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_cnt   = 0;
      lst_idx = 0;
      lst_tk  = 0;
    end else if (m_cnt < ENTRIES) begin
      m_cnt++;
    end
  end

  function automatic int lk_idx(input logic [31:0] pc);
    return int'((pc >> PC_LSB) & 32'(ENTRIES - 1)) ^ m_ghr;
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    return 32'(((idx ^ m_ghr) & (ENTRIES - 1)) << PC_LSB) | (32'($urandom) & 32'hFFFF_FF00);
  endfunction

  task automatic step(input bit pv, input logic [31:0] pc, input bit uv, input int ui, input bit ut);
    exp_t e;
    int   li;
    @(posedge clk);
    #1;
    pred_valid_i = pv;
    pred_pc_i    = pc;
    upd_valid_i  = uv;
    upd_idx_i    = IDX_W'(ui);
    upd_taken_i  = ut;
    if (m_cnt == ENTRIES) begin
      li = lk_idx(pc);
      if (uv) begin
        if (ut) m_ctr[ui] = (m_ctr[ui] == CMAX) ? CMAX : m_ctr[ui] + 1;
        else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        m_ghr = ((m_ghr << 1) | int'(ut)) % ENTRIES;
      end
      if (pv) begin
        e.idx = li;
        e.tk  = (m_ctr[li] >= 2);
        e.cyc = cyc + 1;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic rand_step(input bit allow_upd);
    logic [31:0] pc;
    int          ui;
    pc = 32'($urandom);
    ui = ($urandom_range(0, 2) == 0) ? lk_idx(pc) : int'($urandom_range(0, ENTRIES - 1));
    step(1'($urandom), pc, allow_upd & 1'($urandom), ui, 1'($urandom));
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    pred_valid_i = 1'b0;
    upd_valid_i  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (m_ctr[i]) m_ctr[i] = 0;
    m_ghr = 0;
  endtask

  task automatic wait_ready(input bit noisy);
    int n;
    n = 0;
    while (m_cnt != ENTRIES && n < 200) begin
      if (noisy) rand_step(1'b1);
      else       idle();
      n++;
    end
    if (m_cnt != ENTRIES) begin
      miscompares++;
      $display("FAIL wait_ready: model never reached ready after %0d cycles", n);
    end
  endtask

  // Monitor: checks ready_o every cycle, pops an expectation per prediction pulse,
  // and checks that outputs hold when no prediction is presented.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      vectors++;
      if (ready_o !== (m_cnt == ENTRIES)) begin
        miscompares++;
        $display("FAIL ready cyc=%0d: got %b want %b", cyc, ready_o, m_cnt == ENTRIES);
      end
      vectors++;
      if (pred_valid_o === 1'b1) begin
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_valid cyc=%0d: got pred_valid_o=1 with nothing outstanding", cyc);
        end else begin
          e = q.pop_front();
          if (pred_idx_o !== IDX_W'(e.idx) || pred_taken_o !== e.tk || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL pred cyc=%0d: got idx=%0d taken=%b, want idx=%0d taken=%b at cyc=%0d",
                     cyc, pred_idx_o, pred_taken_o, e.idx, e.tk, e.cyc);
          end
          lst_idx = e.idx;
          lst_tk  = e.tk;
        end
      end else begin
        if (pred_valid_o !== 1'b0 || pred_idx_o !== IDX_W'(lst_idx) || pred_taken_o !== lst_tk) begin
          miscompares++;
          $display("FAIL hold cyc=%0d: got valid=%b idx=%0d taken=%b, want valid=0 idx=%0d taken=%b",
                   cyc, pred_valid_o, pred_idx_o, pred_taken_o, lst_idx, lst_tk);
        end
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          miscompares++;
          $display("FAIL missing_valid cyc=%0d: got no pulse, want idx=%0d taken=%b", cyc, e.idx, e.tk);
        end
      end
    end
  end

  initial begin
    foreach (m_ctr[i]) m_ctr[i] = 0;
    m_ghr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Initialisation sweep with ignored traffic, then every entry predicts not-taken.
    wait_ready(1'b1);
    for (int i = 0; i < ENTRIES; i++) step(1'b1, pc_for(i), 1'b0, 0, 1'b0);

    // Saturation up and down on entry 5.
    do_reset();
    wait_ready(1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 5, 1'b1);
    step(1'b1, pc_for(5), 1'b0, 0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 5, 1'b1);
    step(1'b0, 32'h0, 1'b1, 5, 1'b0);
    step(1'b1, pc_for(5), 1'b0, 0, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 5, 1'b0);
    step(1'b1, pc_for(5), 1'b0, 0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 5, 1'b0);
    step(1'b1, pc_for(5), 1'b0, 0, 1'b0);

    // Bypass: entry 9 weakly not-taken, taken update colliding with a lookup.
    step(1'b0, 32'h0, 1'b1, 9, 1'b1);
    step(1'b1, pc_for(9), 1'b1, 9, 1'b1);

    // Gshare indexing: history T,T,N then PC 0x10.
    do_reset();
    wait_ready(1'b0);
    step(1'b0, 32'h0, 1'b1, 0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 0, 1'b0);
    step(1'b1, 32'h0000_0010, 1'b0, 0, 1'b0);

    // Random mixed traffic.
    for (int i = 0; i < 1500; i++) rand_step(1'b1);

    // Drive every entry to strongly taken, then reset mid-run.
    for (int i = 0; i < ENTRIES; i++) repeat (3) step(1'b0, 32'h0, 1'b1, i, 1'b1);
    do_reset();
    wait_ready(1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 32'($urandom), 1'b0, 0, 1'b0);

    // Throughput: ten back-to-back lookups.
    for (int i = 0; i < 10; i++) step(1'b1, 32'($urandom), 1'b0, 0, 1'b0);

    repeat (3) idle();
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d outstanding predictions, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_pattern_table.md
Name: bp_pattern_table

Overview:
- Parametrised branch pattern history table (PHT). It replaces the single 2-bit predictor FSM with an array of N-bit saturating counters.
- Indexing is gshare: selected PC bits are XORed with a global history register (GHR). GHR_W=0 degenerates to a bimodal table.
- Sits in fetch/decode. Lookup is issued in the fetch stage; update comes from execute when a branch resolves.

Parameters:
- XLEN, 32, PC width.
- IDX_W, 6, table index width; ENTRIES = 2**IDX_W.
- CTR_W, 2, saturating counter width (>=1).
- GHR_W, 6, global history length (0..IDX_W); 0 = bimodal.
- PC_LSB, 2, lowest PC bit used for indexing.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ready_o  out  1  table initialised; lookups and updates are honoured.
- pred_valid_i  in  1  lookup request.
- pred_pc_i  in  XLEN  PC of the instruction being looked up.
- pred_valid_o  out  1  prediction valid; one cycle after an accepted request.
- pred_taken_o  out  1  predicted direction.
- pred_idx_o  out  IDX_W  index used; carried down the pipeline to the update port.
- upd_valid_i  in  1  resolved conditional branch.
- upd_idx_i  in  IDX_W  index returned from pred_idx_o.
- upd_taken_i  in  1  actual outcome.

Behaviour:
- States: INIT, RUN.
- rst (any state, including mid-operation): state=INIT, sweep counter=0, GHR=0, ready_o=0, pred_valid_o=0, pred_taken_o=0, pred_idx_o=0.
- INIT:
  - Writes counter value 0 (strong not-taken) to entry sweep, one entry per cycle, then increments sweep.
  - After writing entry ENTRIES-1, moves to RUN. ready_o=1 from the following cycle, so ENTRIES cycles after rst deasserts.
  - pred_valid_i and upd_valid_i are ignored in INIT; pred_valid_o stays 0.
- Index: idx = pred_pc_i[PC_LSB +: IDX_W] XOR zero-extended GHR. The GHR occupies the low GHR_W bits and uses its pre-update value in the lookup cycle.
- Lookup (RUN):
  - Read is registered; latency 1.
  - pred_valid_o = registered pred_valid_i.
  - pred_idx_o = registered idx.
  - pred_taken_o = MSB of the read counter (counter >= 2**(CTR_W-1)).
  - When pred_valid_o=0, pred_taken_o and pred_idx_o hold their last value.
- Update (RUN), applied at the clock edge:
  - Entry upd_idx_i increments when upd_taken_i=1, saturating at 2**CTR_W-1.
  - Entry upd_idx_i decrements when upd_taken_i=0, saturating at 0.
  - GHR <= {GHR[GHR_W-2:0], upd_taken_i}. No GHR logic when GHR_W=0; width-1 case: GHR <= upd_taken_i.
- Same-cycle lookup and update with idx == upd_idx_i: the read is bypassed and returns the post-update counter value (write-first).
- GHR is non-speculative; only resolved branches shift it. Lookups never modify state.
- Back-to-back lookups every cycle are supported; there is no backpressure.
- Counter storage is a register array or 1R1W RAM with write-first bypass. During INIT the sweep write has exclusive use of the write port.

Decomposition:
- Shared package bp_pkg:
  - state enum {INIT, RUN}.
  - counter encoding constants CTR_MIN=0, CTR_MAX, WEAK_T = 2**(CTR_W-1).
  - sat_next(ctr, taken) function for saturating increment/decrement.
- Sub-module bp_sat_ctr: combinational saturating next-value for one counter, instantiated on the update path and reused by the bypass.

Test Plan:
- Init: rst 1 cycle -> ready_o=0 for exactly 64 cycles, then 1. Lookups during INIT give pred_valid_o=0. Every entry then predicts not-taken.
- Saturate up/down (GHR_W=0 build): 2 taken updates to idx 5, lookup PC 0x14 -> pred_taken_o=1, pred_idx_o=5. 3 more taken, then 1 not-taken -> still taken. 2 further not-taken -> pred_taken_o=0. 3 more not-taken -> counter remains 0, no wrap to 3.
- Bypass: entry 9 at 1 (weak NT); in the same cycle, upd_valid_i=1, upd_idx_i=9, upd_taken_i=1 and a lookup to idx 9 -> next cycle pred_taken_o=1.
- Gshare index: updates T,T,N give GHR=6'b000110. Lookup PC 0x0000_0010 -> pred_idx_o=2 (4 XOR 6).
- Reset mid-run: entries driven to 3 and GHR nonzero; assert rst in RUN -> ready_o low 64 cycles, GHR=0. Lookup of any PC afterwards -> pred_taken_o=0.
- Throughput: lookups on 10 consecutive cycles -> 10 consecutive pred_valid_o pulses, each one cycle after its request, with correct pred_idx_o.
